// File: rtl/expr_pkg.sv
// Shared constants and types for the expression scheduler.
package expr_pkg;

  localparam logic [7:0] CH_EQ  = 8'h3D;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_MUL = 8'h2A;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    FEED    = 2'd1,
    DISCARD = 2'd2,
    REPORT  = 2'd3
  } sched_state_t;

  function automatic logic is_term(input logic [7:0] ch);
    return ch == CH_EQ;
  endfunction

endpackage

// File: rtl/expr_sched_if.sv
// Bus between expr_sched (slave) and its environment: character input,
// recognizer drive/return and the verdict port.
// Both in_* and res_* are valid/ready: a transfer happens on a rising edge
// where valid and ready are both high; valid and data stay stable until then.
interface expr_sched_if
  import expr_pkg::*;
#(
  parameter int LEN_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             chk_clr;
  logic [7:0]       chk_in;
  logic             chk_out;
  logic             res_valid;
  logic             res_ready;
  logic             res_ok;
  logic             res_ovf;
  logic [LEN_W-1:0] res_len;
  sched_state_t     dbg_state;

  modport master (
    output in_valid, in_data, chk_out, res_ready,
    input  in_ready, chk_clr, chk_in, res_valid, res_ok, res_ovf, res_len,
           dbg_state
  );

  modport slave (
    input  in_valid, in_data, chk_out, res_ready,
    output in_ready, chk_clr, chk_in, res_valid, res_ok, res_ovf, res_len,
           dbg_state
  );
endinterface

// File: rtl/expr_fifo.sv
// DEPTH x 8 synchronous FIFO with registered count; head is the oldest entry.
module expr_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/expr_sched.sv
// Buffers characters and feeds one complete '='-terminated expression at a time
// to the external expr recognizer. Optional counters: EXPR_SCHED_STATS_EN.
module expr_sched
  import expr_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic clr,
`ifdef EXPR_SCHED_STATS_EN
  output logic [15:0] stat_ok,
  output logic [15:0] stat_bad,
`endif
  expr_sched_if.slave bus
);
  sched_state_t     state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] term_cnt_q;
  logic [LEN_W-1:0] term_cnt_d;
  logic             res_ok_q;
  logic             res_ovf_q;
  logic [LEN_W-1:0] res_len_q;

  logic       full;
  logic       empty;
  logic [7:0] head;
  logic       push;
  logic       pop;
  logic       head_is_eq;

  assign push       = bus.in_valid && !full;
  assign head_is_eq = is_term(head);
  assign pop        = (state_q == FEED) || ((state_q == DISCARD) && !empty);

  expr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push_i  (push),
    .data_i  (bus.in_data),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  always_comb begin
    term_cnt_d = term_cnt_q;
    case ({push && is_term(bus.in_data), pop && head_is_eq})
      2'b10:   term_cnt_d = term_cnt_q + LEN_W'(1);
      2'b01:   term_cnt_d = term_cnt_q - LEN_W'(1);
      default: term_cnt_d = term_cnt_q;
    endcase
  end

  // The terminator cycle captures chk_out, which still reflects the last real character.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= WAIT;
      len_q      <= '0;
      term_cnt_q <= '0;
      res_ok_q   <= 1'b0;
      res_ovf_q  <= 1'b0;
      res_len_q  <= '0;
    end else begin
      term_cnt_q <= term_cnt_d;
      case (state_q)
        WAIT: begin
          if (term_cnt_q != '0) state_q <= FEED;
          else if (full)        state_q <= DISCARD;
        end
        FEED: begin
          if (head_is_eq) begin
            res_ok_q  <= bus.chk_out && (len_q != '0);
            res_ovf_q <= 1'b0;
            res_len_q <= len_q;
            state_q   <= REPORT;
          end else begin
            len_q <= len_q + LEN_W'(1);
          end
        end
        DISCARD: begin
          if (!empty) begin
            if (head_is_eq) begin
              res_ok_q  <= 1'b0;
              res_ovf_q <= 1'b1;
              res_len_q <= len_q;
              state_q   <= REPORT;
            end else if (len_q != LEN_W'(DEPTH)) begin
              len_q <= len_q + LEN_W'(1);
            end
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            len_q   <= '0;
            state_q <= WAIT;
          end
        end
        default: state_q <= WAIT;
      endcase
    end
  end

`ifdef EXPR_SCHED_STATS_EN
  logic [15:0] stat_ok_q;
  logic [15:0] stat_bad_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      stat_ok_q  <= '0;
      stat_bad_q <= '0;
    end else if ((state_q == REPORT) && bus.res_ready) begin
      if (res_ok_q) begin
        if (stat_ok_q != 16'hFFFF) stat_ok_q <= stat_ok_q + 16'd1;
      end else begin
        if (stat_bad_q != 16'hFFFF) stat_bad_q <= stat_bad_q + 16'd1;
      end
    end
  end

  assign stat_ok  = stat_ok_q;
  assign stat_bad = stat_bad_q;
`endif

  assign bus.in_ready  = !full;
  assign bus.chk_clr   = (state_q != FEED);
  assign bus.chk_in    = ((state_q == FEED) && !head_is_eq) ? head : 8'h00;
  assign bus.res_valid = (state_q == REPORT);
  assign bus.res_ok    = res_ok_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_len   = res_len_q;
  assign bus.dbg_state = state_q;
endmodule

// File: doc/expr_sched.md
# expr_sched

Scheduler that buffers an incoming ASCII character stream and sequences the `expr` recognizer one complete expression at a time. The recognizer has no enable and steps on every clock, so this block holds it in clear until a whole expression, terminated by `=`, is buffered. It then feeds the characters on consecutive cycles and returns one verdict per expression on a valid/ready result port. It sits between the character source and `expr`, and owns `expr`'s `clr` and `in`.

## Interface
- DEPTH, 16, character FIFO depth (power of 2, ≥4); max legal expression length is DEPTH-1 characters plus terminator
- LEN_W, $clog2(DEPTH)+1, width of res_len
- clk  in  1  clock, all state on rising edge
- clr  in  1  reset; synchronous, active-high
- in_valid  in  1  character offered
- in_ready  out  1  = !fifo_full; push when in_valid && in_ready
- in_data  in  8  ASCII character
- chk_clr  out  1  drives expr.clr
- chk_in  out  8  drives expr.in
- chk_out  in  1  expr.out
- res_valid  out  1  verdict available
- res_ready  in  1  consumer accepts verdict
- res_ok  out  1  1 = well-formed expression
- res_ovf  out  1  expression overflowed the FIFO and was discarded
- res_len  out  LEN_W  characters in the expression, excluding `=`

## Operation
- Terminator is `=` (8'h3D). All other bytes are expression characters, judged by `expr`.
- FIFO: registered count. Simultaneous push and pop leave the count unchanged. term_cnt tracks `=` bytes held: +1 on pushing `=`, -1 on popping `=`, both together → unchanged.
- States:
  - WAIT (reset state): chk_clr=1, chk_in=0. If term_cnt>0 → FEED. Else if FIFO full → DISCARD.
  - FEED: chk_clr=0. Pop the FIFO head every cycle; the FIFO is never empty here.
    - Non-terminator: chk_in=head, len+1.
    - `=`: chk_in=0. Capture res_ok=chk_out && len!=0, res_ovf=0, res_len=len → REPORT.
  - DISCARD: chk_clr=1. Pop the head whenever FIFO is non-empty and count discarded characters, saturating at DEPTH. On popping `=`, capture res_ok=0, res_ovf=1, res_len=saturated count → REPORT.
  - REPORT: chk_clr=1, res_valid=1, result fields stable. When res_ready=1, clear len → WAIT.
- Input stays open in every state, subject to in_ready.
- Empty expression (bare `=`): res_ok=0, res_len=0, res_ovf=0.
- A pending clr overrides everything. In the cycle after clr: state WAIT, FIFO empty, term_cnt=0, len=0, FIFO contents lost.

## Timing
- Reset values: in_ready=1, chk_clr=1, chk_in=0, res_valid=0, res_ok=0, res_ovf=0, res_len=0.
- chk_clr and chk_in are decoded from the state register and the FIFO head. The recognizer samples them at the same edge that advances the FIFO.
- chk_out for the character fed at edge k is valid after edge k. Verdict capture on the `=` cycle therefore sees the last character's result.
- Latency:
  - `=` pushed at edge t → term_cnt>0 after t → FEED from cycle t+1.
  - N characters + `=` take N+1 FEED cycles.
  - res_valid rises at the edge ending the `=` cycle.
  - Minimum, with the expression already buffered: N+2 cycles from WAIT to res_valid.
- res_valid && res_ready at edge e → WAIT after e. A next buffered expression starts FEED one cycle later. Peak throughput: one expression per N+3 cycles.
- No bubbles are allowed inside FEED. Each character is fed on consecutive cycles, which is guaranteed because the terminator is already buffered.

## Configuration
- EXPR_SCHED_STATS_EN defined: adds outputs stat_ok and stat_bad, 16 bits each, reset 0. Each REPORT handshake increments stat_ok if res_ok, else stat_bad. Both saturate at 16'hFFFF.
- Undefined: ports and counters absent. All other behaviour is identical.

## Structure
- expr_pkg:
  - ASCII constants: CH_EQ 8'h3D, CH_0 8'h30, CH_9 8'h39, CH_ADD 8'h2B, CH_MUL 8'h2A.
  - sched_state_t enum: WAIT, FEED, DISCARD, REPORT.
- Sub-module expr_fifo: parameterized DEPTH×8 synchronous FIFO with full, empty and head outputs, sync active-high clr.
- expr_sched instantiates expr_fifo only. `expr` is connected externally.

## Test plan
- Reset, then push "1+2*3=" → FEED runs 6 cycles with chk_in 31,2B,32,2A,33,00 → res_ok=1, res_len=5, res_ovf=0.
- Push "1+=" with res_ready held 0 for 5 cycles → res_ok=0, res_len=2. res_valid stays high with stable fields until res_ready=1, then back to WAIT.
- Push "=", then "7=" back-to-back → first verdict ok=0, len=0; second ok=1, len=1; no lost or duplicated characters.
- DEPTH=16: push 20 digits with no `=`, then `=` → in_ready drops while full, DISCARD drains → res_ok=0, res_ovf=1, res_len=16; next "5=" gives ok=1.
- Assert clr mid-FEED of "9*9*9=" → next cycle chk_clr=1, in_ready=1, no res_valid. Then "4=" gives ok=1, len=1.
- With EXPR_SCHED_STATS_EN: 3 good and 2 bad expressions → stat_ok=3, stat_bad=2.
